// File: rtl/key_move_pulser.sv
// Debounced, auto-repeating movement strobes from four active-low push buttons.
// Define KEY_AUTO_REPEAT_EN to enable hold-to-repeat; otherwise each accepted press strobes once.
module key_move_pulser #(
  parameter int unsigned DEBOUNCE_CYCLES = 250000,
  parameter int unsigned REPEAT_DELAY    = 12500000,
  parameter int unsigned REPEAT_PERIOD   = 5000000,
  parameter int unsigned CNT_W           = 24
) (
  input  logic       vga_clk,
  input  logic       reset,
  input  logic       key_up_n,
  input  logic       key_down_n,
  input  logic       key_left_n,
  input  logic       key_right_n,
  output logic       move_up,
  output logic       move_down,
  output logic       move_left,
  output logic       move_right,
  output logic [3:0] held
);

  typedef enum logic [2:0] {
    IDLE,
    PRESS_DB,
    HOLD_DELAY,
    HOLD_REPEAT,
    RELEASE_DB
  } key_state_t;

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
`ifdef KEY_AUTO_REPEAT_EN
  localparam logic [CNT_W-1:0] DELAY_LAST  = CNT_W'(REPEAT_DELAY - 1);
  localparam logic [CNT_W-1:0] PERIOD_LAST = CNT_W'(REPEAT_PERIOD - 1);
`else
  logic unused_repeat_cfg;
  assign unused_repeat_cfg = ^{REPEAT_DELAY, REPEAT_PERIOD};
`endif

  logic [3:0]       raw_n;
  logic [3:0]       sync_0;
  logic [3:0]       sync_1;
  logic [3:0]       pressed;
  key_state_t       state      [4];
  key_state_t       state_next [4];
  logic [CNT_W-1:0] cnt        [4];
  logic [CNT_W-1:0] cnt_next   [4];
  logic [3:0]       in_repeat;
  logic [3:0]       in_repeat_next;
  logic [3:0]       pulse;

  assign raw_n   = {key_right_n, key_left_n, key_down_n, key_up_n};
  assign pressed = ~sync_1;

  // Synchronizers preset to the released level so reset never looks like a press.
  always_ff @(posedge vga_clk or posedge reset) begin
    if (reset) begin
      sync_0 <= 4'b1111;
      sync_1 <= 4'b1111;
    end else begin
      sync_0 <= raw_n;
      sync_1 <= sync_0;
    end
  end

  always_ff @(posedge vga_clk or posedge reset) begin
    if (reset) begin
      for (int k = 0; k < 4; k++) begin
        state[k] <= IDLE;
        cnt[k]   <= '0;
      end
      in_repeat <= 4'b0000;
    end else begin
      for (int k = 0; k < 4; k++) begin
        state[k] <= state_next[k];
        cnt[k]   <= cnt_next[k];
      end
      in_repeat <= in_repeat_next;
    end
  end

  // in_repeat remembers which hold state a bounced release must return to.
  always_comb begin
    in_repeat_next = in_repeat;
    pulse          = 4'b0000;
    for (int k = 0; k < 4; k++) begin
      state_next[k] = state[k];
      cnt_next[k]   = cnt[k];
      case (state[k])
        IDLE: begin
          cnt_next[k] = '0;
          if (pressed[k]) state_next[k] = PRESS_DB;
        end
        PRESS_DB: begin
          if (!pressed[k]) begin
            state_next[k] = IDLE;
            cnt_next[k]   = '0;
          end else if (cnt[k] == DB_LAST) begin
            state_next[k]     = HOLD_DELAY;
            cnt_next[k]       = '0;
            pulse[k]          = 1'b1;
            in_repeat_next[k] = 1'b0;
          end else begin
            cnt_next[k] = cnt[k] + CNT_ONE;
          end
        end
        HOLD_DELAY: begin
          if (!pressed[k]) begin
            state_next[k] = RELEASE_DB;
            cnt_next[k]   = '0;
          end else begin
`ifdef KEY_AUTO_REPEAT_EN
            if (cnt[k] == DELAY_LAST) begin
              state_next[k]     = HOLD_REPEAT;
              cnt_next[k]       = '0;
              pulse[k]          = 1'b1;
              in_repeat_next[k] = 1'b1;
            end else begin
              cnt_next[k] = cnt[k] + CNT_ONE;
            end
`else
            cnt_next[k] = '0;
`endif
          end
        end
`ifdef KEY_AUTO_REPEAT_EN
        HOLD_REPEAT: begin
          if (!pressed[k]) begin
            state_next[k] = RELEASE_DB;
            cnt_next[k]   = '0;
          end else if (cnt[k] == PERIOD_LAST) begin
            cnt_next[k] = '0;
            pulse[k]    = 1'b1;
          end else begin
            cnt_next[k] = cnt[k] + CNT_ONE;
          end
        end
`endif
        RELEASE_DB: begin
          if (pressed[k]) begin
            state_next[k] = in_repeat[k] ? HOLD_REPEAT : HOLD_DELAY;
            cnt_next[k]   = '0;
          end else if (cnt[k] == DB_LAST) begin
            state_next[k] = IDLE;
            cnt_next[k]   = '0;
          end else begin
            cnt_next[k] = cnt[k] + CNT_ONE;
          end
        end
        default: begin
          state_next[k] = IDLE;
          cnt_next[k]   = '0;
        end
      endcase
    end
  end

  // Opposing keys on one axis cancel; the two axes stay independent.
  always_ff @(posedge vga_clk or posedge reset) begin
    if (reset) begin
      move_up    <= 1'b0;
      move_down  <= 1'b0;
      move_left  <= 1'b0;
      move_right <= 1'b0;
    end else begin
      move_up    <= pulse[0] & ~pulse[1];
      move_down  <= pulse[1] & ~pulse[0];
      move_left  <= pulse[2] & ~pulse[3];
      move_right <= pulse[3] & ~pulse[2];
    end
  end

  always_comb begin
    held = 4'b0000;
    for (int k = 0; k < 4; k++) begin
      held[k] = (state[k] == HOLD_DELAY) || (state[k] == HOLD_REPEAT) ||
                (state[k] == RELEASE_DB);
    end
  end

endmodule

// File: tb/tb_key_move_pulser.sv
// Directed bench for key_move_pulser with short debounce/repeat timing.
// Expected repeat strobes depend on whether KEY_AUTO_REPEAT_EN is defined.
module tb_key_move_pulser;

  logic       vga_clk = 1'b0;
  logic       reset;
  logic       key_up_n, key_down_n, key_left_n, key_right_n;
  logic       move_up, move_down, move_left, move_right;
  logic [3:0] held;
  logic [3:0] moves;
  int         checks = 0;
  int         errors = 0;

  key_move_pulser #(
    .DEBOUNCE_CYCLES(4),
    .REPEAT_DELAY   (10),
    .REPEAT_PERIOD  (3),
    .CNT_W          (24)
  ) dut (
    .vga_clk    (vga_clk),
    .reset      (reset),
    .key_up_n   (key_up_n),
    .key_down_n (key_down_n),
    .key_left_n (key_left_n),
    .key_right_n(key_right_n),
    .move_up    (move_up),
    .move_down  (move_down),
    .move_left  (move_left),
    .move_right (move_right),
    .held       (held)
  );

  always #5 vga_clk = ~vga_clk;

  assign moves = {move_right, move_left, move_down, move_up};

  // Strobe cycles of a clean press that is still held: first at 6, then 16, 19, 22 ...
  function automatic logic exp_press(input int c);
    logic hit;
    hit = (c == 6);
`ifdef KEY_AUTO_REPEAT_EN
    if (c >= 16 && ((c - 16) % 3) == 0) hit = 1'b1;
`endif
    return hit;
  endfunction

  task automatic tick();
    @(posedge vga_clk);
    #1;
  endtask

  // Drive raw buttons {right,left,down,up}, then let one rising edge sample them.
  task automatic apply_stimulus(input logic [3:0] keys_n);
    {key_right_n, key_left_n, key_down_n, key_up_n} = keys_n;
    tick();
  endtask

  task automatic check_output(input string tag, input int cyc,
                              input logic [3:0] observed, input logic [3:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s cycle %0d observed %b expected %b", tag, cyc, observed, expected);
    end
  endtask

  task automatic reset_dut();
    {key_right_n, key_left_n, key_down_n, key_up_n} = 4'b1111;
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  initial begin
    {key_right_n, key_left_n, key_down_n, key_up_n} = 4'b1111;
    reset = 1'b1;
    #1;
    check_output("reset_moves", -1, moves, 4'b0000);
    check_output("reset_held", -1, held, 4'b0000);
    reset_dut();
    check_output("post_reset_moves", -1, moves, 4'b0000);
    check_output("post_reset_held", -1, held, 4'b0000);

    $display("[TB] single press on up");
    for (int c = 0; c <= 30; c++) begin
      apply_stimulus(4'b1110);
      check_output("press_moves", c, moves, {3'b000, exp_press(c)});
      check_output("press_held", c, held, (c >= 6) ? 4'b0001 : 4'b0000);
    end

    $display("[TB] glitch on left");
    reset_dut();
    for (int c = 0; c <= 15; c++) begin
      apply_stimulus((c < 3) ? 4'b1011 : 4'b1111);
      check_output("glitch_moves", c, moves, 4'b0000);
      check_output("glitch_held", c, held, 4'b0000);
    end

    $display("[TB] release bounce on right");
    reset_dut();
    for (int c = 0; c <= 24; c++) begin
      apply_stimulus((c < 8 || c == 10) ? 4'b0111 : 4'b1111);
      check_output("bounce_moves", c, moves, (c == 6) ? 4'b1000 : 4'b0000);
      check_output("bounce_held", c, held, (c >= 6 && c <= 16) ? 4'b1000 : 4'b0000);
    end

    $display("[TB] opposing up/down with left");
    reset_dut();
    for (int c = 0; c <= 20; c++) begin
      apply_stimulus(4'b1000);
      check_output("oppose_moves", c, moves, {1'b0, exp_press(c), 2'b00});
      check_output("oppose_held", c, held, (c >= 6) ? 4'b0111 : 4'b0000);
    end

    $display("[TB] reset during hold");
    reset_dut();
    for (int c = 0; c <= 19; c++) begin
      apply_stimulus(4'b1110);
      check_output("prehold_moves", c, moves, {3'b000, exp_press(c)});
    end
    reset = 1'b1;
    #1;
    check_output("abort_moves", 19, moves, 4'b0000);
    check_output("abort_held", 19, held, 4'b0000);
    tick();
    tick();
    reset = 1'b0;
    for (int c = 0; c <= 12; c++) begin
      apply_stimulus(4'b1110);
      check_output("redebounce_moves", c, moves, (c == 6) ? 4'b0001 : 4'b0000);
      check_output("redebounce_held", c, held, (c >= 6) ? 4'b0001 : 4'b0000);
    end

    $display("[TB] long press on down");
    reset_dut();
    for (int c = 0; c <= 39; c++) begin
      apply_stimulus(4'b1101);
      check_output("long_moves", c, moves, {2'b00, exp_press(c), 1'b0});
      check_output("long_held", c, held, (c >= 6) ? 4'b0010 : 4'b0000);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
